// File: rtl/mix_col_seq_pkg.sv
// Shared types and constants for the sequential AES MixColumns block.
package mix_col_seq_pkg;

    localparam int STATE_W  = 128;
    localparam int COL_W    = 32;
    localparam int BYTE_W   = 8;
    localparam int NUM_COLS = 4;

    localparam logic [BYTE_W-1:0] XTIME_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Multiply by x in GF(2^8), folding the overflow bit back with the AES polynomial.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? XTIME_POLY : '0);
    endfunction

endpackage

// File: rtl/col_oper.sv
// Combinational MixColumns transform of one 32-bit column (a0 in the top byte).
module col_oper
    import mix_col_seq_pkg::*;
(
    input  logic [COL_W-1:0] col_i,
    output logic [COL_W-1:0] col_o
);

    logic [BYTE_W-1:0] a0, a1, a2, a3;
    logic [BYTE_W-1:0] x0, x1, x2, x3;

    always_comb begin
        a0 = col_i[31:24];
        a1 = col_i[23:16];
        a2 = col_i[15:8];
        a3 = col_i[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        // 3a is expressed as xtime(a) ^ a.
        col_o[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
        col_o[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
        col_o[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
        col_o[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
    end

endmodule

// File: rtl/mix_col_seq.sv
// Sequential AES MixColumns: one shared column unit, four cycles per state word.
// Defining MIX_COL_SEQ_BYPASS_EN adds in_bypass, which passes a word straight to DONE.
module mix_col_seq
    import mix_col_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:127]     in_data,
`ifdef MIX_COL_SEQ_BYPASS_EN
    input  logic             in_bypass,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     out_data,
    output logic             busy
);

    state_e                      fsm_q, fsm_d;
    logic [1:0]                  col_idx_q, col_idx_d;
    logic [1:0]                  col_sel;
    logic [NUM_COLS-1:0][COL_W-1:0] state_q, state_d;
    logic [STATE_W-1:0]          out_q, out_d;
    logic [COL_W-1:0]            col_in, col_out;
    logic                        accept;
    logic                        bypass;

    col_oper u_col_oper (
        .col_i (col_in),
        .col_o (col_out)
    );

`ifdef MIX_COL_SEQ_BYPASS_EN
    assign bypass = in_bypass;
`else
    assign bypass = 1'b0;
`endif

    // Column 0 occupies the most significant 32 bits of the packed state.
    assign col_sel = 2'd3 - col_idx_q;
    assign col_in  = state_q[col_sel];

    assign in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);
    assign out_data  = out_q;

    always_comb begin
        fsm_d     = fsm_q;
        col_idx_d = col_idx_q;
        state_d   = state_q;
        out_d     = out_q;

        if (accept) begin
            state_d   = in_data;
            col_idx_d = 2'd0;
            if (bypass) begin
                fsm_d = DONE;
                out_d = in_data;
            end else begin
                fsm_d = BUSY;
            end
        end else begin
            case (fsm_q)
                IDLE: ;
                BUSY: begin
                    state_d[col_sel] = col_out;
                    col_idx_d        = col_idx_q + 2'd1;
                    // The result is latched separately so out_data never shows partial work.
                    if (col_idx_q == 2'd3) begin
                        fsm_d = DONE;
                        out_d = state_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_d = IDLE;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            col_idx_q <= 2'd0;
            state_q   <= '0;
            out_q     <= '0;
        end else begin
            fsm_q     <= fsm_d;
            col_idx_q <= col_idx_d;
            state_q   <= state_d;
            out_q     <= out_d;
        end
    end

endmodule

// File: tb/tb_mix_col_seq.sv
// Directed self-checking bench for mix_col_seq with hand-computed MixColumns results.
module tb_mix_col_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_data;
    logic         busy;
`ifdef MIX_COL_SEQ_BYPASS_EN
    logic         in_bypass;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] W1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] WA = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
    localparam logic [127:0] RA = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
    localparam logic [127:0] WB = 128'h2d26314c_2d26314c_2d26314c_2d26314c;
    localparam logic [127:0] RB = 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8;

    always #5 clk = ~clk;

    mix_col_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef MIX_COL_SEQ_BYPASS_EN
        .in_bypass (in_bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one word from IDLE and wait, bounded, for its result.
    task automatic applyStimulus(input logic [127:0] data, input logic [127:0] expRes, input string tag);
        int lat;
        in_valid = 1'b1;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
        checkOutput({tag, " latency"}, 128'(lat), 128'd4);
        checkOutput({tag, " out_valid"}, 128'(out_valid), 128'd1);
        checkOutput({tag, " out_data"}, out_data, expRes);
        tick();
        checkOutput({tag, " back to idle"}, 128'(busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef MIX_COL_SEQ_BYPASS_EN
        in_bypass = 1'b0;
`endif
        tick();
        tick();
        checkOutput("reset out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset busy", 128'(busy), 128'd0);
        checkOutput("reset out_data", out_data, 128'd0);
        checkOutput("reset in_ready", 128'(in_ready), 128'd1);
        rst_n = 1'b1;
        tick();
        checkOutput("post-release out_data", out_data, 128'd0);

        applyStimulus(W1, R1, "single");

        // Result must hold under backpressure and block new input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp out_valid", 128'(out_valid), 128'd1);
            checkOutput("bp out_data", out_data, R1);
            checkOutput("bp in_ready", 128'(in_ready), 128'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp release in_ready", 128'(in_ready), 128'd1);
        tick();
        checkOutput("bp handshake out_valid", 128'(out_valid), 128'd0);
        checkOutput("bp handshake busy", 128'(busy), 128'd0);

        // Back-to-back: second word is accepted in the DONE cycle of the first.
        in_valid = 1'b1;
        in_data  = WA;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput("b2b A pending", 128'(out_valid), 128'd0);
        end
        tick();
        checkOutput("b2b A out_valid", 128'(out_valid), 128'd1);
        checkOutput("b2b A out_data", out_data, RA);
        checkOutput("b2b A in_ready", 128'(in_ready), 128'd1);
        in_data = WB;
        tick();
        checkOutput("b2b B accepted busy", 128'(busy), 128'd1);
        checkOutput("b2b B accepted out_valid", 128'(out_valid), 128'd0);
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput("b2b B pending", 128'(out_valid), 128'd0);
        end
        tick();
        checkOutput("b2b B out_valid", 128'(out_valid), 128'd1);
        checkOutput("b2b B out_data", out_data, RB);
        tick();
        checkOutput("b2b idle", 128'(busy), 128'd0);

        // Reset while the third column is being processed.
        in_valid = 1'b1;
        in_data  = W1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", 128'(out_valid), 128'd0);
        checkOutput("midreset busy", 128'(busy), 128'd0);
        checkOutput("midreset out_data", out_data, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("midreset in_ready", 128'(in_ready), 128'd1);
        applyStimulus(WB, RB, "post-reset");

        // in_valid pulses during BUSY must not be accepted.
        in_valid = 1'b1;
        in_data  = W1;
        tick();
        in_data = WA;
        checkOutput("protocol in_ready busy0", 128'(in_ready), 128'd0);
        tick();
        checkOutput("protocol in_ready busy1", 128'(in_ready), 128'd0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("protocol out_valid", 128'(out_valid), 128'd1);
        checkOutput("protocol out_data", out_data, R1);
        tick();
        checkOutput("protocol idle", 128'(busy), 128'd0);

`ifdef MIX_COL_SEQ_BYPASS_EN
        in_valid  = 1'b1;
        in_bypass = 1'b1;
        in_data   = 128'h00112233_44556677_8899aabb_ccddeeff;
        tick();
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        checkOutput("bypass out_valid", 128'(out_valid), 128'd1);
        checkOutput("bypass out_data", out_data, 128'h00112233_44556677_8899aabb_ccddeeff);
        tick();
        checkOutput("bypass idle", 128'(busy), 128'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
